// File: rtl/pc_ctrl.sv
// pc_ctrl: program-sequencing controller for the 4-bit PC register.
// Holds a 16 x 8 instruction store and decodes the word at pc_i each cycle.
// Issues registered backward-jump requests, runs the loop counter for
// decrement-and-branch, and implements halt/resume. The PC register applies
// pc_next = pc - jump_offset[3:0] - 2 whenever jump_en is high.
module pc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] pc_i,
    input  logic       prog_we,
    input  logic [3:0] prog_addr,
    input  logic [7:0] prog_data,
    input  logic       start,
    output logic       jump_en,
    output logic [5:0] jump_offset,
    output logic [3:0] cnt_o,
    output logic       halt_o
);

    typedef enum logic [1:0] {
        StRun,
        StFlush,
        StHalt,
        StResume
    } state_e;

    localparam logic [1:0] OpNop  = 2'b00;
    localparam logic [1:0] OpLdc  = 2'b01;
    localparam logic [1:0] OpDjnz = 2'b10;
    localparam logic [1:0] OpJmpb = 2'b11;

    // A halt request lands while the PC is at A+1; offset 15 takes it back to A.
    localparam logic [5:0] HaltReturnOffset = 6'd15;
    // While halted the PC sits at A; offset 14 maps A onto itself.
    localparam logic [5:0] HaltFreezeOffset = 6'd14;

    logic [7:0] r_mem [16];
    state_e     r_state;
    logic       r_jump_en;
    logic [5:0] r_jump_offset;
    logic [3:0] r_cnt;
    logic       r_halt;

    logic [7:0] w_word;
    logic [1:0] w_op;
    logic [3:0] w_dist;
    logic [3:0] w_cnt_dec;
    logic       w_take_djnz;
    logic       w_take_jmpb;
    logic       w_take;
    logic       w_halt_dec;
    logic [5:0] w_offset;
    logic       w_unused_bit;

    // Instruction store: cleared to NOP on reset, written on any cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (prog_we) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    // Decode of the word at the current PC; a same-cycle write is not yet visible.
    always_comb begin
        w_word       = r_mem[pc_i];
        w_op         = w_word[7:6];
        w_dist       = w_word[3:0];
        w_cnt_dec    = r_cnt - 4'd1;
        w_take_djnz  = (w_op == OpDjnz) && (w_cnt_dec != 4'd0);
        w_take_jmpb  = (w_op == OpJmpb) && !w_word[5];
        w_halt_dec   = (w_op == OpJmpb) && w_word[5];
        w_take       = w_take_djnz || w_take_jmpb;
        // Request is applied from A+1, so d-1 (mod 16) lands on A-d.
        w_offset     = {2'b00, w_dist - 4'd1};
        // Operand bit 4 has no meaning in any opcode.
        w_unused_bit = w_word[4];
    end

    // Control FSM with registered jump request, counter and halt flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= StRun;
            r_jump_en     <= 1'b0;
            r_jump_offset <= 6'd0;
            r_cnt         <= 4'd0;
            r_halt        <= 1'b0;
        end else begin
            unique case (r_state)
                StRun: begin
                    if (w_op == OpLdc) begin
                        r_cnt <= w_dist;
                    end else if (w_op == OpDjnz) begin
                        r_cnt <= w_cnt_dec;
                    end

                    if (w_take) begin
                        r_state       <= StFlush;
                        r_jump_en     <= 1'b1;
                        r_jump_offset <= w_offset;
                    end else if (w_halt_dec) begin
                        r_state       <= StHalt;
                        r_jump_en     <= 1'b1;
                        r_jump_offset <= HaltReturnOffset;
                        r_halt        <= 1'b1;
                    end else begin
                        r_jump_en     <= 1'b0;
                        r_jump_offset <= 6'd0;
                    end
                end

                // The word fetched at A+1 is discarded; the PC is moving to the target.
                StFlush: begin
                    r_state       <= StRun;
                    r_jump_en     <= 1'b0;
                    r_jump_offset <= 6'd0;
                end

                StHalt: begin
                    if (start) begin
                        r_state       <= StResume;
                        r_jump_en     <= 1'b0;
                        r_jump_offset <= 6'd0;
                        r_halt        <= 1'b0;
                    end else begin
                        r_jump_en     <= 1'b1;
                        r_jump_offset <= HaltFreezeOffset;
                    end
                end

                // The HALT word at A is fetched again here and must not re-halt.
                StResume: begin
                    r_state       <= StRun;
                    r_jump_en     <= 1'b0;
                    r_jump_offset <= 6'd0;
                end
            endcase
        end
    end

    assign jump_en     = r_jump_en;
    assign jump_offset = r_jump_offset;
    assign cnt_o       = r_cnt;
    assign halt_o      = r_halt;

endmodule

// File: tb/tb_pc_ctrl.sv
// Bench for pc_ctrl: a PC register model closes the loop, a target-based
// reference model is compared every cycle, and directed programs pin
// literal PC/offset sequences.
module tb_pc_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] pc_q;
    logic       prog_we = 1'b0;
    logic [3:0] prog_addr = 4'd0;
    logic [7:0] prog_data = 8'd0;
    logic       start = 1'b0;
    logic       jump_en;
    logic [5:0] jump_offset;
    logic [3:0] cnt_o;
    logic       halt_o;

    logic       tb_hold = 1'b0;
    logic [3:0] tb_hold_pc = 4'd0;
    logic       rec = 1'b0;

    int total = 0;
    int bad = 0;

    int t_pc[$];
    int t_je[$];
    int t_off[$];
    int t_cnt[$];
    int t_halt[$];

    int ld_n;
    logic [3:0] ld_addr [8];
    logic [7:0] ld_data [8];

    // Reference model state
    logic [7:0] m_mem [16];
    logic [3:0] m_cnt;
    bit         m_halted;
    bit         m_ignore;
    logic [3:0] m_halt_addr;
    logic       exp_je;
    logic [5:0] exp_off;

    pc_ctrl u_dut (
        .clk        (clk),
        .rst        (rst),
        .pc_i       (pc_q),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .start      (start),
        .jump_en    (jump_en),
        .jump_offset(jump_offset),
        .cnt_o      (cnt_o),
        .halt_o     (halt_o)
    );

    always #5 clk = ~clk;

    // PC register driven by the controller; the bench may park it while loading.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= 4'd0;
        end else if (tb_hold) begin
            pc_q <= tb_hold_pc;
        end else if (jump_en) begin
            pc_q <= pc_q - jump_offset[3:0] - 4'd2;
        end else begin
            pc_q <= pc_q + 4'd1;
        end
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Offset that moves the PC from 'from' to 'to' under pc - off - 2.
    function automatic logic [5:0] off_for(input logic [3:0] from, input logic [3:0] to);
        logic [3:0] t;
        t = from - to - 4'd2;
        return {2'b00, t};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        m_cnt       = 4'd0;
        m_halted    = 1'b0;
        m_ignore    = 1'b0;
        m_halt_addr = 4'd0;
        exp_je      = 1'b0;
        exp_off     = 6'd0;
    endtask

    // Advance the model by one clock edge using the inputs about to be sampled.
    task automatic model_step();
        logic [7:0] w;
        logic [3:0] d;
        logic [3:0] a1;
        logic [3:0] tgt;
        logic       nje;
        logic [5:0] noff;
        w    = m_mem[pc_q];
        d    = w[3:0];
        a1   = pc_q + 4'd1;
        tgt  = pc_q - d;
        nje  = 1'b0;
        noff = 6'd0;
        if (m_halted) begin
            if (start) begin
                m_halted = 1'b0;
                m_ignore = 1'b1;
            end else begin
                nje  = 1'b1;
                noff = off_for(m_halt_addr, m_halt_addr);
            end
        end else if (m_ignore) begin
            m_ignore = 1'b0;
        end else begin
            case (w[7:6])
                2'b01: m_cnt = d;
                2'b10: begin
                    m_cnt = m_cnt - 4'd1;
                    if (m_cnt != 4'd0) begin
                        nje      = 1'b1;
                        noff     = off_for(a1, tgt);
                        m_ignore = 1'b1;
                    end
                end
                2'b11: begin
                    if (w[5]) begin
                        m_halted    = 1'b1;
                        m_halt_addr = pc_q;
                        nje         = 1'b1;
                        noff        = off_for(a1, pc_q);
                    end else begin
                        nje      = 1'b1;
                        noff     = off_for(a1, tgt);
                        m_ignore = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (prog_we) m_mem[prog_addr] = prog_data;
        exp_je  = nje;
        exp_off = noff;
    endtask

    // Per-cycle compare against the model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("reset jump_en", int'(jump_en), 0);
                check("reset jump_offset", int'(jump_offset), 0);
                check("reset cnt_o", int'(cnt_o), 0);
                check("reset halt_o", int'(halt_o), 0);
                model_reset();
            end else begin
                check("cyc jump_en", int'(jump_en), int'(exp_je));
                check("cyc jump_offset", int'(jump_offset), int'(exp_off));
                check("cyc cnt_o", int'(cnt_o), int'(m_cnt));
                check("cyc halt_o", int'(halt_o), int'(m_halted));
                if (rec) begin
                    t_pc.push_back(int'(pc_q));
                    t_je.push_back(int'(jump_en));
                    t_off.push_back(int'(jump_offset));
                    t_cnt.push_back(int'(cnt_o));
                    t_halt.push_back(int'(halt_o));
                end
                model_step();
            end
        end
    end

    task automatic clear_trace();
        t_pc.delete();
        t_je.delete();
        t_off.delete();
        t_cnt.delete();
        t_halt.delete();
    endtask

    // Reset, load ld_* with the PC parked at 15 (NOP), then release at 'st'.
    task automatic reset_load(input logic [3:0] st);
        @(posedge clk); #1;
        rst = 1'b0; prog_we = 1'b0; start = 1'b0; tb_hold = 1'b0; rec = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; tb_hold = 1'b1; tb_hold_pc = 4'd15;
        for (int i = 0; i < ld_n; i++) begin
            prog_we = 1'b1; prog_addr = ld_addr[i]; prog_data = ld_data[i];
            @(posedge clk); #1;
        end
        prog_we = 1'b0; tb_hold_pc = st;
        @(posedge clk); #1;
        tb_hold = 1'b0;
        clear_trace();
        rec = 1'b1;
    endtask

    int e_pc[21];

    initial begin
        model_reset();

        // Reset with random inputs
        for (int i = 0; i < 5; i++) begin
            prog_we = 1'($urandom); prog_addr = 4'($urandom); prog_data = 8'($urandom);
            start = 1'($urandom);
            @(posedge clk); #1;
        end
        prog_we = 1'b0; start = 1'b0; rst = 1'b1; rec = 1'b1; clear_trace();
        repeat (3) @(posedge clk); #1;
        rec = 1'b0;
        check("rst first pc", t_pc[0], 0);
        check("rst first jump_en", t_je[0], 0);
        check("rst second jump_en", t_je[1], 0);
        check("rst cnt", t_cnt[2], 0);

        // Loop program, halt, then resume
        ld_n = 4;
        ld_addr[0] = 4'd0; ld_data[0] = 8'h43;
        ld_addr[1] = 4'd1; ld_data[1] = 8'h00;
        ld_addr[2] = 4'd2; ld_data[2] = 8'h81;
        ld_addr[3] = 4'd3; ld_data[3] = 8'hE0;
        reset_load(4'd0);
        repeat (14) @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk); #1;
        rec = 1'b0;
        e_pc = '{0, 1, 2, 3, 1, 2, 3, 1, 2, 3, 4, 3, 3, 3, 3, 3, 4, 5, 6, 7, 8};
        for (int i = 0; i < 21; i++) check($sformatf("loop pc[%0d]", i), t_pc[i], e_pc[i]);
        check("loop cnt after ldc", t_cnt[1], 3);
        check("loop jump1 en", t_je[3], 1);
        check("loop jump1 off", t_off[3], 0);
        check("loop jump2 en", t_je[6], 1);
        check("loop jump2 off", t_off[6], 0);
        check("loop fallthrough en", t_je[9], 0);
        check("loop cnt end", t_cnt[13], 0);
        check("halt rise", t_halt[10], 1);
        check("halt off15", t_off[10], 15);
        check("halt en15", t_je[10], 1);
        check("halt off14", t_off[11], 14);
        check("halt hold", t_halt[13], 1);
        check("resume en a", t_je[15], 0);
        check("resume en b", t_je[16], 0);
        check("resume halt fall", t_halt[15], 0);
        for (int i = 16; i < 21; i++) check($sformatf("no rehalt[%0d]", i), t_halt[i], 0);

        // DJNZ with the counter at zero
        ld_n = 1;
        ld_addr[0] = 4'd5; ld_data[0] = 8'h82;
        reset_load(4'd5);
        repeat (4) @(posedge clk); #1;
        rec = 1'b0;
        check("djnz0 pc0", t_pc[0], 5);
        check("djnz0 pc1", t_pc[1], 6);
        check("djnz0 pc2", t_pc[2], 3);
        check("djnz0 cnt", t_cnt[1], 15);
        check("djnz0 en", t_je[1], 1);
        check("djnz0 off", t_off[1], 1);

        // Self-jump with a jump word in the flush slot, then reset mid-jump
        ld_n = 2;
        ld_addr[0] = 4'd7; ld_data[0] = 8'hC0;
        ld_addr[1] = 4'd8; ld_data[1] = 8'hC1;
        reset_load(4'd7);
        repeat (5) @(posedge clk); #1;
        rec = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("self pc[%0d]", i), t_pc[i], (i % 2 == 0) ? 7 : 8);
            check($sformatf("self en[%0d]", i), t_je[i], (i % 2 == 0) ? 0 : 1);
            check($sformatf("self off[%0d]", i), t_off[i], (i % 2 == 0) ? 0 : 15);
        end
        check("pre-reset jump_en", int'(jump_en), 1);
        rst = 1'b0;
        #1;
        check("async clear jump_en", int'(jump_en), 0);
        check("async clear offset", int'(jump_offset), 0);

        // Write collision: HALT written to the address being decoded
        ld_n = 0;
        reset_load(4'd2);
        prog_we = 1'b1; prog_addr = 4'd2; prog_data = 8'hE0;
        @(posedge clk); #1;
        prog_we = 1'b0;
        repeat (18) @(posedge clk); #1;
        rec = 1'b0;
        check("coll pc1", t_pc[1], 3);
        check("coll no halt", t_halt[1], 0);
        check("coll no jump", t_je[1], 0);
        check("coll revisit pc", t_pc[16], 2);
        check("coll halt later", t_halt[17], 1);
        check("coll halt off", t_off[17], 15);
        check("pre-reset halt_o", int'(halt_o), 1);
        rst = 1'b0;
        #1;
        check("async clear halt_o", int'(halt_o), 0);
        check("async clear jump_en h", int'(jump_en), 0);

        // Random programs, writes, resumes and occasional resets
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            prog_we   = ($urandom_range(3) == 0);
            prog_addr = 4'($urandom);
            prog_data = 8'($urandom);
            start     = ($urandom_range(4) == 0);
            rst       = ($urandom_range(400) != 0);
            @(posedge clk); #1;
        end
        prog_we = 1'b0; start = 1'b0; rst = 1'b1;
        repeat (2) @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Program-sequencing controller that drives the `jump_en` / `jump_offset` inputs of the 4-bit program counter register. Holds a 16 x 8 instruction store, reads the word at the current `pc_i` each cycle, and decodes it. Issues registered backward-jump requests, including a loop counter with decrement-and-branch and a halt/resume mechanism. It is the control-side counterpart to the PC register in the CPU core.

## Interface
Parameters: none (widths fixed: 4-bit PC, 8-bit instruction, 6-bit offset).
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `pc_i`  in  4  current PC from the PC register
- `prog_we`  in  1  instruction-store write enable
- `prog_addr`  in  4  write address
- `prog_data`  in  8  write data
- `start`  in  1  resume request, sampled only in HALT
- `jump_en`  out  1  registered jump request to the PC register
- `jump_offset`  out  6  registered offset; PC update is `pc_next = pc - jump_offset[3:0] - 2` (mod 16)
- `cnt_o`  out  4  loop counter
- `halt_o`  out  1  high while in HALT

## Operation
- Instruction store: 16 x 8 registers, cleared to 0x00 (NOP) by reset; written at the clock edge when `prog_we`=1. The read is combinational `mem[pc_i]`. A write to the address being decoded in the same cycle decodes the old word.
- Encoding `[7:6]` opcode, `[5:0]` operand; `d = operand[3:0]` is the backward distance (target = A - d mod 16, where A is the decoded address):
  - 00 NOP: no action.
  - 01 LDC: `cnt <= operand[3:0]`.
  - 10 DJNZ: `cnt <= cnt - 1` (4-bit wrap; 0 becomes 15); jump if the new cnt != 0.
  - 11 JMPB: `operand[5]`=0 gives an unconditional jump to A - d; `operand[5]`=1 gives HALT.
- Jump offset: `jump_offset = {2'b00, (d - 1) mod 16}`. It is applied one cycle later, while the PC is at A+1, so the target is A - d. `d`=0 re-executes A.
- `jump_offset` = 0 whenever `jump_en` = 0.
- FSM states: RUN, FLUSH, HALT, RESUME.
  - RUN: decode `mem[pc_i]`.
    - Jump taken: next state FLUSH, with `jump_en`=1 and the offset registered.
    - HALT decoded: next state HALT, with `jump_en`=1 and `jump_offset`=15 (PC returns to A).
    - Otherwise: stay in RUN, `jump_en`=0.
  - FLUSH: the fetched word (at A+1) is ignored, with no cnt change. Next state RUN, `jump_en`=0.
  - HALT: `halt_o`=1 and `jump_en`=1 with `jump_offset`=14, which freezes the PC. If `start`=1, next state RESUME with `jump_en`=0.
  - RESUME: the fetched word (the HALT at A) is ignored. Next state RUN; the PC advances to A+1.
- `start` outside HALT is ignored. `prog_we` is honoured in every state.

## Timing
- Reset (async assert, sync-clean deassert): state RUN, `jump_en`=0, `jump_offset`=0, `cnt_o`=0, `halt_o`=0, memory cleared.
- Decode-to-request latency is 1 cycle; the request-to-PC change happens at the next edge. A taken jump therefore costs exactly 1 flushed slot.
- `halt_o` rises in the cycle after the HALT is decoded, together with the offset-15 request. It falls in the cycle after `start` is sampled.
- `cnt_o` updates at the edge that decodes LDC/DJNZ and is visible the next cycle.
- Reset mid-jump or mid-halt clears `jump_en` immediately (asynchronous), so no stale request reaches the PC.
- Back-to-back jumps: a jump word in the FLUSH slot never fires.

## Test plan
- Reset: hold `rst`=0 with random inputs, then release. Required: all outputs 0 and the first decode is at PC 0 (NOP), `jump_en`=0.
- Loop with a PC model in the bench: program mem0=0x43 (LDC 3), mem1=0x00, mem2=0x81 (DJNZ d=1), mem3=0xE0 (HALT).
  - Required PC sequence: 0,1,2,3,1,2,3,1,2,3,4,3,3,...
  - `jump_offset`=0 on both loop jumps.
  - `cnt_o` ends at 0.
  - `halt_o`=1 from the cycle the PC reads 4 onward, with offset 15 then 14.
- Resume: in the above halt, pulse `start` for 1 cycle. Required: `jump_en`=0 for 2 cycles; the PC goes 3, 4, 5, with no re-halt.
- DJNZ from zero: cnt=0 with DJNZ d=2 at address 5. Required: cnt becomes 15, the jump is taken with `jump_offset`=1, and the PC goes 5, 6, 3.
- Self-jump and flush: JMPB d=0 (0xC0) at 7 with JMPB 0xC1 at 8. Required: `jump_offset`=15 and the PC loops 7, 8, 7, 8; the word at 8 never causes a jump.
- Write collision: `prog_we` to the address equal to `pc_i` with HALT data while NOP is stored. Required: no halt this cycle; the new word decodes on the next visit.
